// File: rtl/serial_sub_pkg.sv
// Shared FSM state encoding for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_fa_struc.sv
// 1-bit full-adder cell used as the serial subtractor's only arithmetic element.
module fa_struc (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic p;
  logic g;

  assign p    = a ^ b;
  assign g    = a & b;
  assign sum  = p ^ cin;
  assign cout = g | (p & cin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a + ~b + 1, one bit per cycle, LSB first.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_inv_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             sum_c;
  logic             cout_c;

  fa_struc u_fa (
    .sum  (sum_c),
    .cout (cout_c),
    .a    (a_sr[0]),
    .b    (b_inv_sr[0]),
    .cin  (carry)
  );

  // Control, operand shifters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_inv_sr <= '0;
      res_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= '0;
      borrow   <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr     <= a;
            b_inv_sr <= ~b;
            carry    <= 1'b1;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> 1;
          b_inv_sr <= b_inv_sr >> 1;
          res_sr   <= {sum_c, res_sr[WIDTH-1:1]};
          carry    <= cout_c;
          cnt      <= cnt + CW'(1);
          // On the MSB step, carry holds the carry into the MSB
          if (cnt == CW'(WIDTH - 1)) begin
            diff   <= {sum_c, res_sr[WIDTH-1:1]};
            borrow <= ~cout_c;
            ovf    <= carry ^ cout_c;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Directed and exhaustive checks of serial_sub at WIDTH=8 and WIDTH=4.
module tb_serial_sub;

  logic       clk;
  logic       rst_n;
  logic       start8, busy8, done8, borrow8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start4, busy4, done4, borrow4, ovf4;
  logic [3:0] a4, b4, diff4;

  int nvec;
  int nerr;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .ovf(ovf8)
  );

  serial_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow(borrow4), .ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Caller is at a negedge; start is accepted on the next rising edge.
  task automatic op8(input logic [7:0] ea, input logic [7:0] eb,
                     output logic [7:0] rd, output logic rb, output logic ro,
                     output int lat);
    a8 = ea; b8 = eb; start8 = 1'b1;
    @(posedge clk); @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); @(negedge clk);
      if (done8) begin lat = j; break; end
    end
    rd = diff8; rb = borrow8; ro = ovf8;
    @(posedge clk); @(negedge clk);
    chk("done8_single", 32'(done8), 32'd0);
    chk("busy8_after", 32'(busy8), 32'd0);
  endtask

  task automatic op4(input logic [3:0] ea, input logic [3:0] eb,
                     output logic [3:0] rd, output logic rb, output logic ro,
                     output int lat, output logic dn_after);
    a4 = ea; b4 = eb; start4 = 1'b1;
    @(posedge clk); @(negedge clk);
    start4 = 1'b0;
    lat = -1;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); @(negedge clk);
      if (done4) begin lat = j; break; end
    end
    rd = diff4; rb = borrow4; ro = ovf4;
    @(posedge clk); @(negedge clk);
    dn_after = done4;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [3:0] rd4;
    logic       rb, ro, dn_after, bad_busy;
    int         lat, first_done, second_done, sa, sb, sd;

    nvec = 0; nerr = 0;
    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tbl[4] = '{8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    tbl[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
    tbl[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    tbl[9] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

    rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
    a8 = 8'h5A; b8 = 8'h11; a4 = 4'h0; b4 = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_borrow", 32'(borrow8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);

    // First start offered together with reset release
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op8(tbl[i].a, tbl[i].b, rd, rb, ro, lat);
      chk($sformatf("lat[%0d]", i), 32'(lat), 32'd8);
      chk($sformatf("diff[%0d]", i), 32'(rd), 32'(tbl[i].d));
      chk($sformatf("borrow[%0d]", i), 32'(rb), 32'(tbl[i].br));
      chk($sformatf("ovf[%0d]", i), 32'(ro), 32'(tbl[i].ov));
      chk($sformatf("hold[%0d]", i), 32'(diff8), 32'(tbl[i].d));
    end

    // Restart attempt during RUN must not disturb the operation
    a8 = 8'h5A; b8 = 8'h21; start8 = 1'b1;
    @(posedge clk); @(negedge clk);
    start8 = 1'b0;
    lat = -1; bad_busy = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); @(negedge clk);
      if (j == 3) begin start8 = 1'b1; a8 = 8'h00; b8 = 8'h00; end
      if (j == 6) start8 = 1'b0;
      if (!busy8) bad_busy = 1'b1;
      if (done8) begin lat = j; break; end
    end
    chk("restart_lat", 32'(lat), 32'd8);
    chk("restart_busy", 32'(bad_busy), 32'd0);
    chk("restart_diff", 32'(diff8), 32'h39);
    chk("restart_borrow", 32'(borrow8), 32'd0);
    chk("restart_ovf", 32'(ovf8), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("restart_end_busy", 32'(busy8), 32'd0);
    chk("restart_end_done", 32'(done8), 32'd0);

    // Back-to-back with start held high: done every 10 edges
    a8 = 8'h09; b8 = 8'h04; start8 = 1'b1;
    first_done = -1; second_done = -1;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk); @(negedge clk);
      if (done8) begin
        if (first_done < 0) first_done = j;
        else begin second_done = j; break; end
      end
    end
    start8 = 1'b0;
    chk("b2b_first", 32'(first_done), 32'd9);
    chk("b2b_period", 32'(second_done - first_done), 32'd10);
    chk("b2b_diff", 32'(diff8), 32'h05);
    repeat (2) @(negedge clk);

    // Reset four edges into RUN aborts the operation
    a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
    @(posedge clk); @(negedge clk);
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_borrow", 32'(borrow8), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn_after = 1'b0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (done8 || busy8) dn_after = 1'b1;
    end
    chk("abort_no_done", 32'(dn_after), 32'd0);
    chk("abort_diff_after", 32'(diff8), 32'd0);
    op8(8'h44, 8'h47, rd, rb, ro, lat);
    chk("post_abort_lat", 32'(lat), 32'd8);
    chk("post_abort_diff", 32'(rd), 32'hFD);
    chk("post_abort_borrow", 32'(rb), 32'd1);
    chk("post_abort_ovf", 32'(ro), 32'd0);

    // Exhaustive WIDTH=4 against an arithmetic reference
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        op4(4'(ia), 4'(ib), rd4, rb, ro, lat, dn_after);
        sa = (ia > 7) ? ia - 16 : ia;
        sb = (ib > 7) ? ib - 16 : ib;
        sd = sa - sb;
        chk($sformatf("w4_lat %0d-%0d", ia, ib), 32'(lat), 32'd4);
        chk($sformatf("w4_diff %0d-%0d", ia, ib), 32'(rd4), 32'((ia - ib) & 15));
        chk($sformatf("w4_borrow %0d-%0d", ia, ib), 32'(rb), 32'(ia < ib));
        chk($sformatf("w4_ovf %0d-%0d", ia, ib), 32'(ro), 32'((sd < -8) || (sd > 7)));
        chk($sformatf("w4_once %0d-%0d", ia, ib), 32'(dn_after), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
